// File: rtl/collision_ctrl.sv
// Collision controller: per-frame bee-vs-obstacle box test, hit debounce,
// one-frame hit pulse, lives bookkeeping and a PLAY / INVULN / OVER
// state machine that drives the invulnerability flicker and game-over screen.
module collision_ctrl #(
  parameter int LIVES         = 3,   // lives loaded at reset/restart (1..7)
  parameter int HIT_CONFIRM   = 2,   // consecutive overlapping frames per hit (1..7)
  parameter int INVULN_FRAMES = 60   // invulnerable frames after a non-fatal hit (1..1023)
) (
  input  logic       frame_clk,
  input  logic       Reset,
  input  logic       Restart,
  input  logic [9:0] BeeX,
  input  logic [9:0] BeeY,
  input  logic [9:0] BeeS,
  input  logic [9:0] ObsX,
  input  logic [9:0] ObsY,
  input  logic [9:0] ObsWidth,
  input  logic [9:0] ObsHeight,
  output logic       Overlap,
  output logic       HitPulse,
  output logic       Invuln,
  output logic       GameOver,
  output logic [2:0] Lives
);

  typedef enum logic [1:0] {
    PLAY   = 2'd0,
    INVULN = 2'd1,
    OVER   = 2'd2
  } state_t;

  localparam logic [2:0] LIVES_INIT = 3'(LIVES);
  localparam logic [2:0] HIT_LAST   = 3'(HIT_CONFIRM - 1);
  localparam logic [9:0] INV_LOAD   = 10'(INVULN_FRAMES);

  state_t     state;
  logic [2:0] hit_cnt;
  logic [9:0] inv_cnt;

  // Box-overlap test; 11-bit arithmetic so BeeS + half-width cannot wrap.
  logic [10:0] dx, dy, lim_x, lim_y;
  logic        ov;

  // Absolute center distances and per-axis contact limits; touching edges overlap.
  always_comb begin
    // NOTE: every always_comb output gets a value on every path, so no latch is inferred.
    dx    = (BeeX >= ObsX) ? {1'b0, BeeX - ObsX} : {1'b0, ObsX - BeeX};
    dy    = (BeeY >= ObsY) ? {1'b0, BeeY - ObsY} : {1'b0, ObsY - BeeY};
    lim_x = {1'b0, BeeS} + ({1'b0, ObsWidth} >> 1);
    lim_y = {1'b0, BeeS} + ({1'b0, ObsHeight} >> 1);
    ov    = (dx <= lim_x) && (dy <= lim_y);
  end

  // Game state machine with registered outputs; Reset > Restart > state logic.
  always_ff @(posedge frame_clk or posedge Reset) begin
    if (Reset) begin
      state    <= PLAY;
      Lives    <= LIVES_INIT;
      hit_cnt  <= '0;
      inv_cnt  <= '0;
      Overlap  <= 1'b0;
      HitPulse <= 1'b0;
      Invuln   <= 1'b0;
      GameOver <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      Overlap  <= ov;
      HitPulse <= 1'b0;
      if (Restart) begin
        state    <= PLAY;
        Lives    <= LIVES_INIT;
        hit_cnt  <= '0;
        inv_cnt  <= '0;
        Invuln   <= 1'b0;
        GameOver <= 1'b0;
      end else begin
        case (state)
          PLAY: begin
            if (!ov) begin
              hit_cnt <= '0;
            end else if (hit_cnt == HIT_LAST) begin
              // Contact persisted long enough: register the hit.
              hit_cnt  <= '0;
              HitPulse <= 1'b1;
              Lives    <= (Lives != 3'd0) ? Lives - 3'd1 : 3'd0;
              if (Lives <= 3'd1) begin
                state    <= OVER;
                GameOver <= 1'b1;
              end else begin
                state   <= INVULN;
                Invuln  <= 1'b1;
                inv_cnt <= INV_LOAD;
              end
            end else begin
              hit_cnt <= hit_cnt + 3'd1;
            end
          end
          INVULN: begin
            hit_cnt <= '0;
            if (inv_cnt <= 10'd1) begin
              state   <= PLAY;
              Invuln  <= 1'b0;
              inv_cnt <= '0;
            end else begin
              inv_cnt <= inv_cnt - 10'd1;
            end
          end
          OVER: begin
            hit_cnt  <= '0;
            Lives    <= 3'd0;
            GameOver <= 1'b1;
          end
          default: begin
            state    <= PLAY;
            hit_cnt  <= '0;
            inv_cnt  <= '0;
            Invuln   <= 1'b0;
            GameOver <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule
